// File: rtl/addsub_serial.sv
// ---------------------------------------------------------------------------
// addsub_serial
//
// Purpose:
//   Bit-serial (slice-serial) adder/subtractor. An N-bit add or subtract is
//   carried out CHUNK bits per clock, least-significant slice first. A single
//   carry register ripples between slices, so only a CHUNK-bit adder is needed.
//   Unsigned and two's-complement signed interpretations are supported. The
//   block reports carry/borrow, signed overflow, zero, and the sign of the
//   exact (unwrapped) result.
//
// Parameters:
//   N      operand / result width in bits
//   CHUNK  bits processed per clock; must divide N (CHUNK = N is one slice)
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset; aborts any operation in flight
//   i_start     request, accepted when i_start = 1 and o_ready = 1
//   o_ready     unit is idle and can accept a request
//   i_a, i_b    operands, sampled only at acceptance
//   i_sub       1: a - b, 0: a + b (sampled at acceptance)
//   i_signed    1: two's complement operands, 0: unsigned (sampled at acceptance)
//   o_out       result modulo 2^N
//   o_carry     carry-out for add, borrow (a < b unsigned) for subtract
//   o_overflow  signed overflow, always 0 for unsigned operations
//   o_zero      result is zero
//   o_neg       sign of the mathematically exact result
//   o_valid     one-cycle pulse; outputs hold until the next pulse or reset
// ---------------------------------------------------------------------------
module addsub_serial #(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_sub,
    input  logic         i_signed,
    output logic [N-1:0] o_out,
    output logic         o_carry,
    output logic         o_overflow,
    output logic         o_zero,
    output logic         o_neg,
    output logic         o_valid
);

    // Number of slices and width of the slice counter. A single-slice
    // configuration still gets a 1-bit counter so the logic stays uniform.
    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int L          = N / SAFE_CHUNK;
    localparam int KW         = (L > 1) ? $clog2(L) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(L - 1);

    // Refuse to build a configuration whose slices do not tile the word.
    if ((CHUNK < 1) || (N < 1) || ((N % SAFE_CHUNK) != 0)) begin : g_bad_params
        $fatal(1, "addsub_serial: CHUNK (%0d) must be >= 1 and divide N (%0d)", CHUNK, N);
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Control state
    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;

    // Latched request. Operands are shifted right one slice per clock so the
    // current slice is always in the low CHUNK bits; their sign bits are kept
    // separately because the shifting destroys the MSBs.
    logic [N-1:0]    opA_q, opA_d;
    logic [N-1:0]    opB_q, opB_d;
    logic            sub_q, sub_d;
    logic            signed_q, signed_d;
    logic            signA_q, signA_d;
    logic            signB_q, signB_d;
    logic            carry_q, carry_d;

    // Result being assembled. Each new slice enters at the top and the word
    // shifts right, so after L slices slice 0 has arrived at bit 0.
    logic [N-1:0]    acc_q, acc_d;

    // Registered outputs
    logic [N-1:0]    out_q, out_d;
    logic            carryFlag_q, carryFlag_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic            neg_q, neg_d;
    logic            valid_q, valid_d;

    // Slice datapath
    logic [CHUNK-1:0] bSlice;
    logic [CHUNK:0]   sliceSum;
    logic [N-1:0]     accNext;

    // Flag candidates, meaningful on the edge that processes the last slice
    logic             signR;
    logic             carryNext;
    logic             ovfNext;
    logic             zeroNext;
    logic             negNext;

    // One CHUNK-bit slice of a + (b XOR sub) + c. Subtraction is a + ~b + 1,
    // where the +1 comes from the carry register being preset to sub.
    always_comb begin
        bSlice   = opB_q[CHUNK-1:0] ^ {CHUNK{sub_q}};
        sliceSum = {1'b0, opA_q[CHUNK-1:0]} + {1'b0, bSlice} + {{CHUNK{1'b0}}, carry_q};
        accNext  = (acc_q >> CHUNK) | (N'(sliceSum[CHUNK-1:0]) << (N - CHUNK));
    end

    // Flags derived from the completed result. The final carry of a - b is
    // the complement of the borrow, hence the XOR with sub. In signed mode
    // the exact result's sign is the wrapped sign bit corrected by overflow;
    // in unsigned mode only a borrowing subtraction is negative.
    always_comb begin
        signR     = accNext[N-1];
        carryNext = sliceSum[CHUNK] ^ sub_q;
        if (sub_q) begin
            ovfNext = signed_q & (signA_q != signB_q) & (signR != signA_q);
        end else begin
            ovfNext = signed_q & (signA_q == signB_q) & (signR != signA_q);
        end
        zeroNext  = (accNext == '0);
        if (signed_q) begin
            negNext = signR ^ ovfNext;
        end else begin
            negNext = sub_q & carryNext;
        end
    end

    // Next-state logic: accept in IDLE, process one slice per clock in RUN,
    // publish result and flags together with the valid pulse on the last slice.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        sub_d       = sub_q;
        signed_d    = signed_q;
        signA_d     = signA_q;
        signB_d     = signB_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        out_d       = out_q;
        carryFlag_d = carryFlag_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        valid_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    opA_d    = i_a;
                    opB_d    = i_b;
                    sub_d    = i_sub;
                    signed_d = i_signed;
                    signA_d  = i_a[N-1];
                    signB_d  = i_b[N-1];
                    carry_d  = i_sub;
                    acc_d    = '0;
                    k_d      = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                opA_d   = opA_q >> CHUNK;
                opB_d   = opB_q >> CHUNK;
                carry_d = sliceSum[CHUNK];
                acc_d   = accNext;
                k_d     = k_q + KW'(1);
                if (k_q == LAST_K) begin
                    out_d       = accNext;
                    carryFlag_d = carryNext;
                    ovf_d       = ovfNext;
                    zero_d      = zeroNext;
                    neg_d       = negNext;
                    valid_d     = 1'b1;
                    k_d         = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // State and data registers. Reset wins over a simultaneous start and
    // clears the published outputs, so an aborted operation never reports.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            opA_q       <= '0;
            opB_q       <= '0;
            sub_q       <= 1'b0;
            signed_q    <= 1'b0;
            signA_q     <= 1'b0;
            signB_q     <= 1'b0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            out_q       <= '0;
            carryFlag_q <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            sub_q       <= sub_d;
            signed_q    <= signed_d;
            signA_q     <= signA_d;
            signB_q     <= signB_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            carryFlag_q <= carryFlag_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            valid_q     <= valid_d;
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_out      = out_q;
    assign o_carry    = carryFlag_q;
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;
    assign o_neg      = neg_q;
    assign o_valid    = valid_q;

endmodule

// File: tb/tb_addsub_serial.sv
// ---------------------------------------------------------------------------
// tb_addsub_serial
//
// Purpose:
//   Self-checking bench for addsub_serial. A directed instance (N=8, CHUNK=4)
//   covers reset, latency, handshake and flag corner cases; a sweep of
//   instances with different (N, CHUNK) runs randomised operations. Each issued
//   request pushes its expected result, computed with plain wide arithmetic,
//   into a queue; a monitor pops and compares on every o_valid.
// ---------------------------------------------------------------------------
module tb_addsub_serial;

    typedef struct packed {
        logic [63:0] out;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic on the operands' values, wrapped
    // to n bits afterwards; flags come from range tests on the exact value.
    function automatic exp_t refModel(input int n, input logic [63:0] a, input logic [63:0] b,
                                      input logic sub, input logic sgn);
        exp_t            e;
        longint unsigned mask;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned sum;
        longint          sa;
        longint          sb;
        longint          exact;
        longint          maxV;
        longint          minV;
        mask = (64'd1 << n) - 64'd1;
        ua   = a & mask;
        ub   = b & mask;
        sum  = 0;
        e    = '0;
        if (sub) begin
            e.out   = (ua - ub) & mask;
            e.carry = (ua < ub);
        end else begin
            sum     = ua + ub;
            e.out   = sum & mask;
            e.carry = ((sum >> n) != 0);
        end
        e.zero = (e.out == 0);
        if (sgn) begin
            sa = longint'(ua);
            sb = longint'(ub);
            if (((ua >> (n - 1)) & 1) != 0) sa = sa - (longint'(1) << n);
            if (((ub >> (n - 1)) & 1) != 0) sb = sb - (longint'(1) << n);
            exact = sub ? (sa - sb) : (sa + sb);
            maxV  = (longint'(1) << (n - 1)) - 1;
            minV  = -(longint'(1) << (n - 1));
            e.ovf = (exact > maxV) || (exact < minV);
            e.neg = (exact < 0);
        end else begin
            e.ovf = 1'b0;
            e.neg = sub && (ua < ub);
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // -----------------------------------------------------------------------
    // Directed instance, N=8 CHUNK=4
    // -----------------------------------------------------------------------
    logic       mRst = 1'b1;
    logic       mStart = 1'b0;
    logic       mReady;
    logic [7:0] mA = '0;
    logic [7:0] mB = '0;
    logic       mSub = 1'b0;
    logic       mSigned = 1'b0;
    logic [7:0] mOut;
    logic       mCarry, mOvf, mZero, mNeg, mValid;
    exp_t       mQ[$];

    addsub_serial #(.N(8), .CHUNK(4)) u_main (
        .i_clk(clk), .i_rst(mRst), .i_start(mStart), .o_ready(mReady),
        .i_a(mA), .i_b(mB), .i_sub(mSub), .i_signed(mSigned),
        .o_out(mOut), .o_carry(mCarry), .o_overflow(mOvf), .o_zero(mZero),
        .o_neg(mNeg), .o_valid(mValid)
    );

    always @(negedge clk) begin : mainMonitor
        exp_t e;
        if (mValid === 1'b1) begin
            checkOutput("main valid with request pending", 64'(mQ.size() > 0), 64'd1);
            if (mQ.size() > 0) begin
                e = mQ.pop_front();
                checkOutput("main out", 64'(mOut), e.out);
                checkOutput("main flags c/v/z/n", 64'({mCarry, mOvf, mZero, mNeg}),
                            64'({e.carry, e.ovf, e.zero, e.neg}));
            end
        end
    end

    // Called at a negedge with the unit ready; returns at the negedge in the
    // o_valid cycle, with lat = negedges counted since the request was driven.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                 input logic sgn, output int lat);
        mA = a; mB = b; mSub = sub; mSigned = sgn; mStart = 1'b1;
        mQ.push_back(refModel(8, 64'(a), 64'(b), sub, sgn));
        lat = 0;
        do begin
            @(negedge clk);
            mStart = 1'b0;
            lat++;
            if (mValid !== 1'b1) checkOutput("main ready during RUN", 64'(mReady), 64'd0);
        end while (mValid !== 1'b1 && lat < 40);
    endtask

    // -----------------------------------------------------------------------
    // Width sweep: (8,4) (8,1) (8,8) (16,4) (32,8), randomised operations
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < 5; g++) begin : g_sweep
        localparam int GN = (g == 3) ? 16 : (g == 4) ? 32 : 8;
        localparam int GC = (g == 1) ? 1 : (g == 2) ? 8 : (g == 4) ? 8 : 4;
        localparam int GL = GN / GC;

        logic          rst = 1'b1;
        logic          start = 1'b0;
        logic          ready;
        logic [GN-1:0] a = '0;
        logic [GN-1:0] b = '0;
        logic          sub = 1'b0;
        logic          sgn = 1'b0;
        logic [GN-1:0] out;
        logic          carry, ovf, zero, neg, valid;
        exp_t          q[$];
        bit            done = 1'b0;

        addsub_serial #(.N(GN), .CHUNK(GC)) u_dut (
            .i_clk(clk), .i_rst(rst), .i_start(start), .o_ready(ready),
            .i_a(a), .i_b(b), .i_sub(sub), .i_signed(sgn),
            .o_out(out), .o_carry(carry), .o_overflow(ovf), .o_zero(zero),
            .o_neg(neg), .o_valid(valid)
        );

        // Mix fully random operands with all-ones and MSB-only edge values.
        function automatic logic [GN-1:0] pickOp();
            logic [GN-1:0] v;
            case ($urandom_range(0, 3))
                1:       v = '1;
                2:       v = GN'(64'd1 << (GN - 1));
                default: v = GN'($urandom);
            endcase
            return v;
        endfunction

        always @(negedge clk) begin : sweepMonitor
            exp_t e;
            if (valid === 1'b1) begin
                checkOutput($sformatf("sweep N=%0d C=%0d valid with request pending", GN, GC),
                            64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    checkOutput($sformatf("sweep N=%0d C=%0d out", GN, GC), 64'(out), e.out);
                    checkOutput($sformatf("sweep N=%0d C=%0d flags c/v/z/n", GN, GC),
                                64'({carry, ovf, zero, neg}), 64'({e.carry, e.ovf, e.zero, e.neg}));
                end
            end
        end

        initial begin : sweepStim
            int            lat;
            logic [GN-1:0] ra;
            logic [GN-1:0] rb;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ra = pickOp();
                rb = pickOp();
                a = ra; b = rb;
                sub = 1'($urandom_range(0, 1));
                sgn = 1'($urandom_range(0, 1));
                start = 1'b1;
                q.push_back(refModel(GN, 64'(ra), 64'(rb), sub, sgn));
                lat = 0;
                do begin
                    @(negedge clk);
                    start = 1'b0;
                    lat++;
                end while (valid !== 1'b1 && lat < 100);
                checkOutput($sformatf("sweep N=%0d C=%0d latency", GN, GC), 64'(lat), 64'(GL + 1));
            end
            done = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Directed sequence and end of test
    // -----------------------------------------------------------------------
    initial begin : mainSeq
        int lat;
        int waitCount;
        repeat (3) @(negedge clk);
        checkOutput("reset ready", 64'(mReady), 64'd1);
        checkOutput("reset out", 64'(mOut), 64'd0);
        checkOutput("reset flags c/v/z/n/valid", 64'({mCarry, mOvf, mZero, mNeg, mValid}), 64'd0);
        mRst = 1'b0;
        @(negedge clk);

        applyStimulus(8'h05, 8'h03, 1'b1, 1'b0, lat);
        checkOutput("latency 05-03", 64'(lat), 64'd3);
        checkOutput("ready in valid cycle", 64'(mReady), 64'd1);
        checkOutput("05-03 out", 64'(mOut), 64'h02);
        checkOutput("05-03 flags c/v/z/n", 64'({mCarry, mOvf, mZero, mNeg}), 64'b0000);

        applyStimulus(8'h03, 8'h05, 1'b1, 1'b0, lat);
        checkOutput("03-05 out", 64'(mOut), 64'hFE);
        checkOutput("03-05 flags c/v/z/n", 64'({mCarry, mOvf, mZero, mNeg}), 64'b1001);

        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1, lat);
        checkOutput("signed 7F+01 out", 64'(mOut), 64'h80);
        checkOutput("signed 7F+01 flags c/v/z/n", 64'({mCarry, mOvf, mZero, mNeg}), 64'b0100);

        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, lat);
        checkOutput("unsigned 7F+01 flags c/v/z/n", 64'({mCarry, mOvf, mZero, mNeg}), 64'b0000);

        applyStimulus(8'h80, 8'h01, 1'b1, 1'b1, lat);
        checkOutput("signed 80-01 out", 64'(mOut), 64'h7F);
        checkOutput("signed 80-01 flags c/v/z/n", 64'({mCarry, mOvf, mZero, mNeg}), 64'b0101);

        // Issued in the o_valid cycle of the previous request: back-to-back.
        applyStimulus(8'hAA, 8'hAA, 1'b1, 1'b1, lat);
        checkOutput("back-to-back latency", 64'(lat), 64'd3);
        checkOutput("AA-AA out", 64'(mOut), 64'h00);
        checkOutput("AA-AA flags c/v/z/n", 64'({mCarry, mOvf, mZero, mNeg}), 64'b0010);

        // A start held high into RUN with different operands must be ignored.
        mA = 8'h21; mB = 8'h0F; mSub = 1'b0; mSigned = 1'b0; mStart = 1'b1;
        mQ.push_back(refModel(8, 64'(8'h21), 64'(8'h0F), 1'b0, 1'b0));
        @(negedge clk);
        mA = 8'h99; mB = 8'h11; mSub = 1'b1;
        @(negedge clk);
        mStart = 1'b0;
        lat = 2;
        while (mValid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ignored-start latency", 64'(lat), 64'd3);
        checkOutput("ignored-start out", 64'(mOut), 64'h30);
        repeat (5) @(negedge clk);

        // Reset on the edge after acceptance aborts the operation.
        mA = 8'h10; mB = 8'h01; mSub = 1'b1; mSigned = 1'b0; mStart = 1'b1;
        @(negedge clk);
        mStart = 1'b0;
        mRst = 1'b1;
        @(negedge clk);
        mRst = 1'b0;
        checkOutput("abort ready", 64'(mReady), 64'd1);
        checkOutput("abort out", 64'(mOut), 64'd0);
        checkOutput("abort flags c/v/z/n/valid", 64'({mCarry, mOvf, mZero, mNeg, mValid}), 64'd0);
        repeat (6) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), lat);
            checkOutput("main random latency", 64'(lat), 64'd3);
        end

        waitCount = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done &&
                 g_sweep[3].done && g_sweep[4].done) && waitCount < 20000) begin
            @(negedge clk);
            waitCount++;
        end
        checkOutput("sweep completion", 64'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done &&
                                            g_sweep[3].done && g_sweep[4].done), 64'd1);
        repeat (5) @(negedge clk);
        checkOutput("main queue drained", 64'(mQ.size()), 64'd0);
        checkOutput("sweep 8/4 queue drained", 64'(g_sweep[0].q.size()), 64'd0);
        checkOutput("sweep 8/1 queue drained", 64'(g_sweep[1].q.size()), 64'd0);
        checkOutput("sweep 8/8 queue drained", 64'(g_sweep[2].q.size()), 64'd0);
        checkOutput("sweep 16/4 queue drained", 64'(g_sweep[3].q.size()), 64'd0);
        checkOutput("sweep 32/8 queue drained", 64'(g_sweep[4].q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] time limit");
    end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, multi-cycle successor to the combinational subtractor.
- Performs N-bit addition or subtraction in CHUNK-bit slices, one slice per clock, least-significant slice first, with a ripple carry held in a register between slices.
- Supports unsigned and two's-complement signed interpretation and reports carry/borrow, signed overflow, zero and true-sign flags.
- Sits in the datapath wherever a narrow, area-cheap arithmetic unit with a start/ready/valid handshake is preferred over a full-width combinational subtractor.

Parameters:
- N, 8: operand and result width in bits.
- CHUNK, 4: bits processed per clock. Must divide N; elaboration fails with a fatal error otherwise. CHUNK=N is legal and gives single-slice operation.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  request; accepted on a rising edge where i_start=1 and o_ready=1.
- o_ready  output  1  high when a new request can be accepted.
- i_a  input  N  first operand, sampled only at acceptance.
- i_b  input  N  second operand, sampled only at acceptance.
- i_sub  input  1  sampled at acceptance. 1: compute a-b. 0: compute a+b.
- i_signed  input  1  sampled at acceptance. 1: operands are two's complement. 0: operands are unsigned.
- o_out  output  N  N-bit result, modulo 2^N.
- o_carry  output  1  add: carry-out. Sub: borrow, i.e. 1 when a<b unsigned. Valid in both modes.
- o_overflow  output  1  signed overflow. Forced to 0 when the latched i_signed=0.
- o_zero  output  1  1 when o_out==0.
- o_neg  output  1  sign of the mathematically exact result (see Behaviour).
- o_valid  output  1  one-cycle pulse; result and flags are valid from this cycle on.

Behaviour:
- Reset (i_rst=1 at an edge):
  - Next state is IDLE and the slice counter is cleared.
  - o_ready=1; o_out, o_carry, o_overflow, o_zero, o_neg and o_valid are all 0.
  - Reset overrides i_start on the same edge.
  - Reset during RUN aborts the operation: no o_valid is produced.
- States: IDLE and RUN. L = N/CHUNK.
- IDLE:
  - o_ready=1.
  - On acceptance: latch a, b, sub and signed; set carry register = sub; clear the slice counter k; go to RUN.
- RUN:
  - o_ready=0.
  - Each edge computes slice k as a[k] + (b[k] XOR {CHUNK{sub}}) + c.
  - The CHUNK-bit sum is written into result slice k, c takes the slice carry-out, and k increments.
  - On the edge that processes slice L-1:
    - Register o_out and all flags.
    - Pulse o_valid for the following cycle.
    - Return to IDLE.
- Latency:
  - Request accepted at edge 0.
  - o_valid is high in the cycle after edge L; o_ready is high in that same cycle.
  - A new request may be accepted on the edge ending the o_valid cycle, so back-to-back throughput is one result per L+1 cycles.
- i_start while o_ready=0 is ignored. Operand or mode changes during RUN have no effect.
- Outputs hold their last values until the next o_valid update or reset.
- Flags, with c_out = final carry, r = result, and the signs taken from the MSBs of a, b and r:
  - o_carry = c_out XOR sub.
  - o_overflow (signed mode only):
    - add: sa==sb && sr!=sa.
    - sub: sa!=sb && sr!=sa.
  - o_zero = (r == 0).
  - o_neg, signed mode: sr XOR overflow.
  - o_neg, unsigned mode: sub AND borrow. Unsigned add gives 0.

Test Plan:
- N=8, CHUNK=4, unsigned sub 0x05-0x03 -> o_out=0x02, carry=0, zero=0, neg=0; o_valid high exactly in the cycle after the 2nd edge following acceptance; o_ready=0 during the 2 RUN cycles.
- Unsigned sub 0x03-0x05 -> o_out=0xFE, carry=1, neg=1, overflow=0.
- Signed add 0x7F+0x01 -> o_out=0x80, overflow=1, neg=0, carry=0. Same operands with unsigned add -> overflow=0, neg=0.
- Signed sub 0x80-0x01 -> o_out=0x7F, overflow=1, neg=1, carry=0. Then sub 0xAA-0xAA -> o_out=0x00, zero=1, carry=0.
- Reset mid-operation: accept 0x10-0x01, assert i_rst at the next edge -> no o_valid pulse, all outputs 0, o_ready=1. An i_start pulse during RUN is ignored: exactly one o_valid per accepted request. A back-to-back request accepted in the o_valid cycle completes correctly.
- Width sweep: repeat a randomised add/sub comparison against a full-width reference model for (N,CHUNK) = (8,1), (8,8), (16,4) and (32,8) -> bit-exact o_out and flags; latency = N/CHUNK+1 cycles.
